fetch_redirect_ctrl: RTL

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

---
 rtl/common.sv | 14 +
 rtl/pipes.sv | 14 +
 rtl/fetch_redirect_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/common.sv
// Package common: constants and helpers shared across the core front end.
//   PC_RESET  - architectural reset fetch address
//   CNT_MAX   - ceiling for 16-bit event counters
//   sat_inc16 - increment that sticks at CNT_MAX instead of wrapping
package common;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipes.sv
// Package pipes: pipeline-control types for the front end.
//   fetch_state_t - fetch controller state
//     FETCH : request outstanding or being issued at fetch_pc
//     DRAIN : waiting for a response that will be thrown away after a redirect
//     HOLD  : response captured while decode was stalled, replayed from a buffer
package pipes;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: instruction fetch PC sequencer with redirect handling.
// Issues one instruction-bus request at a time at fetch_pc, presents returned
// words to the fetch/decode register, buffers a word that arrives while decode
// is stalled, and discards responses made stale by a decode-stage redirect.
//
// Ports
//   clk            in   1  clock, rising edge
//   resetn         in   1  synchronous active-low reset
//   redirect       in   1  decode-stage redirect request
//   redirect_pc    in  64  redirect target
//   stall          in   1  fetch/decode register cannot accept this cycle
//   ireq_valid     out  1  instruction-bus request valid
//   ireq_addr      out 64  instruction-bus request address
//   iresp_data_ok  in   1  instruction-bus response valid
//   iresp_data     in  32  instruction-bus response word
//   f_valid        out  1  instruction presented to fetch/decode register
//   f_pc           out 64  PC of presented instruction
//   f_instr        out 32  presented instruction
//   fetch_pc       out 64  current fetch PC (last_pc for decode's compare)
//   discard_cnt    out 16  saturating count of discarded responses
module fetch_redirect_ctrl
  import common::*;
  import pipes::*;
#(
  parameter logic [63:0] PCINIT = PC_RESET
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic [63:0] fetch_pc,
  output logic [15:0] discard_cnt
);

  fetch_state_t state, state_nxt;
  logic [63:0]  pend_pc;
  logic [63:0]  hold_pc;
  logic [31:0]  hold_instr;
  logic         take_redirect;

  // A redirect only counts in a cycle where decode can move.
  assign take_redirect = redirect & ~stall;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        // stall blocks take_redirect, so a stalled response always parks in HOLD
        if (iresp_data_ok) begin
          if (stall) state_nxt = HOLD;
        end else if (take_redirect) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (iresp_data_ok) state_nxt = FETCH;
      end
      HOLD: begin
        if (take_redirect || !stall) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs are forced idle while resetn is low so the bus sees no request
  // in the reset cycle even though state still holds its old value.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = fetch_pc;
    f_valid    = 1'b0;
    f_pc       = fetch_pc;
    f_instr    = iresp_data;
    if (resetn) begin
      case (state)
        FETCH: begin
          ireq_valid = 1'b1;
          // A word arriving under stall is still presented; decode simply
          // does not take it, and the HOLD buffer replays it afterwards.
          f_valid    = iresp_data_ok & ~take_redirect;
        end
        DRAIN: begin
          ireq_valid = 1'b1;
        end
        HOLD: begin
          f_valid = ~take_redirect;
          f_pc    = hold_pc;
          f_instr = hold_instr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc    <= PCINIT;
      pend_pc     <= '0;
      hold_pc     <= '0;
      hold_instr  <= '0;
      discard_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (iresp_data_ok) begin
            if (take_redirect) begin
              fetch_pc    <= redirect_pc;
              discard_cnt <= sat_inc16(discard_cnt);
            end else if (stall) begin
              hold_pc    <= fetch_pc;
              hold_instr <= iresp_data;
            end else begin
              fetch_pc <= fetch_pc + 64'd4;
            end
          end else if (take_redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        DRAIN: begin
          // fetch_pc stays on the stale address until the response lands so
          // the outstanding request keeps a stable address.
          if (iresp_data_ok) begin
            discard_cnt <= sat_inc16(discard_cnt);
            fetch_pc    <= take_redirect ? redirect_pc : pend_pc;
          end else if (take_redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        HOLD: begin
          if (take_redirect) begin
            fetch_pc <= redirect_pc;
          end else if (!stall) begin
            fetch_pc <= hold_pc + 64'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
